branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ADDR_W, default 32, meaning PC and target width in bits.
REQ-002 Parameter ENTRIES, default 16, meaning number of direct-mapped BTB entries; power of 2, at least 2; IDX_W = log2(ENTRIES).
REQ-003 Parameter CTR_W, default 2, meaning width of the saturating direction counter, at least 1.
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  reset, asynchronous and active-low.
REQ-006 lkp_pc_i  input  ADDR_W  IF-stage PC to predict.
REQ-007 pred_hit_o  output  1  lookup PC matches a valid entry.
REQ-008 pred_taken_o  output  1  predict taken; equals pred_hit_o AND counter MSB.
REQ-009 pred_target_o  output  ADDR_W  predicted target; equals the stored target when pred_taken_o=1, otherwise lkp_pc_i+4.
REQ-010 upd_valid_i  input  1  resolved branch or jump update this cycle.
REQ-011 upd_pc_i  input  ADDR_W  PC of the resolved instruction.
REQ-012 upd_taken_i  input  1  actual outcome; jumps are driven as 1.
REQ-013 upd_target_i  input  ADDR_W  actual taken target.
REQ-014 upd_mispred_i  input  1  the predictor was wrong for this update; qualified by upd_valid_i.
REQ-015 flush_i  input  1  invalidate all entries.
REQ-016 perf_clr_i  input  1  clear the mispredict counter.
REQ-017 mispred_cnt_o  output  32  count of qualified mispredicts.

Function
REQ-018 Index is pc[IDX_W+1:2]. Tag is pc[ADDR_W-1:IDX_W+2]. Each entry holds valid, tag, target and counter.
REQ-019 Lookup is combinational from lkp_pc_i and registered state, with zero-cycle latency.
REQ-020 A lookup in the same cycle as an update to the same index returns the pre-update entry; there is no bypass.
REQ-021 Update on a hit with upd_taken_i=1: counter increments and saturates at 2^CTR_W-1; target is overwritten with upd_target_i.
REQ-022 Update on a hit with upd_taken_i=0: counter decrements and saturates at 0; target is unchanged.
REQ-023 Update on a miss with upd_taken_i=1: allocate the entry and overwrite any alias. Set valid=1, tag, target, and counter=2^(CTR_W-1) (weakly taken).
REQ-024 Update on a miss with upd_taken_i=0: no state change.
REQ-025 An update takes effect at the next rising edge; a lookup in the following cycle sees it.
REQ-026 flush_i=1 clears every valid bit at the next edge. Counters and targets are left as they are.
REQ-027 If flush_i and upd_valid_i are both asserted, flush wins and the update is dropped.
REQ-028 mispred_cnt_o increments by 1 on each edge where upd_valid_i AND upd_mispred_i, and saturates at 0xFFFFFFFF.
REQ-029 flush_i does not dropped-gate the mispredict count; the count still increments.
REQ-030 perf_clr_i=1 loads 0 into the counter, taking priority over an increment in the same cycle.
REQ-031 pred_target_o arithmetic is modulo 2^ADDR_W; lkp_pc_i = all-ones gives lkp_pc_i+4 = 3.

Reset
REQ-032 While rst_i=0, regardless of clock, all valid bits are 0.
REQ-033 While rst_i=0, all counters are 2^(CTR_W-1)-1 (weakly not-taken), all targets are 0, and mispred_cnt_o = 0.
REQ-034 During and after reset until the first allocation: pred_hit_o = 0, pred_taken_o = 0, pred_target_o = lkp_pc_i+4.
REQ-035 Reset asserted mid-update aborts the update; state equals reset state.
REQ-036 Deassertion of rst_i is synchronous to clk_i and is externally synchronised.

Verification (ENTRIES=16, CTR_W=2, ADDR_W=32)
REQ-037 Reset, then lookup 0x44 -> hit=0, taken=0, target=0x48, mispred_cnt_o=0.
REQ-038 Update pc=0x44, taken=1, target=0x100; next-cycle lookup 0x44 -> hit=1, taken=1 (ctr=2), target=0x100.
REQ-039 Same entry: two updates with taken=0 -> ctr=0, lookup taken=0, target=0x48. Three updates with taken=1 -> ctr=3; a fourth keeps ctr=3.
REQ-040 Alias: update pc=0x84 (index 1, tag 2), taken=1, target=0x200.
REQ-041 After REQ-040, lookup 0x44 -> hit=0.
REQ-042 After REQ-040, lookup 0x84 -> target=0x200.
REQ-043 Same-cycle update and lookup of pc=0x44 -> the lookup shows the old entry.
REQ-044 flush_i together with upd_valid_i (pc=0x44, taken=1, mispred=1) -> all hit=0 afterwards and mispred_cnt_o=1.
REQ-045 perf_clr_i together with a mispredict update -> mispred_cnt_o=0.
REQ-046 Assert rst_i=0 asynchronously mid-run -> outputs return to reset values before the next edge.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters and a mispredict counter.
// Latency: lookup is combinational (zero cycles); updates, flush and counter changes land on the next rising edge.
// Backpressure: none; every update is accepted in the cycle it is presented.
//
// Ports:
//   clk_i, rst_i (async active-low)
//   lkp_pc_i -> pred_hit_o / pred_taken_o / pred_target_o   IF-stage prediction
//   upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i, upd_mispred_i  resolved-branch training
//   flush_i      invalidate every entry (targets and counters are kept)
//   perf_clr_i   clear mispred_cnt_o
//   mispred_cnt_o  saturating count of qualified mispredicts
module branch_predictor #(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] lkp_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_mispred_i,
  input  logic              flush_i,
  input  logic              perf_clr_i,
  output logic [31:0]       mispred_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  // Newly allocated entries start weakly taken; reset leaves them weakly not-taken.
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [ADDR_W-1:0]  r_tgt [ENTRIES];
  logic [CTR_W-1:0]   r_ctr [ENTRIES];
  logic [31:0]        r_mispred_cnt;

  logic [IDX_W-1:0] w_lkp_idx;
  logic [TAG_W-1:0] w_lkp_tag;
  logic             w_lkp_hit;
  logic             w_lkp_taken;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic [CTR_W-1:0] w_ctr_cur;
  logic [CTR_W-1:0] w_ctr_nxt;
  logic             w_unused_pc;

  // Instructions are word aligned, so the two low PC bits take no part in index or tag.
  assign w_unused_pc = ^upd_pc_i[1:0];

  // Lookup path: reads registered state only, so a same-cycle update is not visible.
  assign w_lkp_idx   = lkp_pc_i[IDX_W+1:2];
  assign w_lkp_tag   = lkp_pc_i[ADDR_W-1:IDX_W+2];
  assign w_lkp_hit   = r_valid[w_lkp_idx] && (r_tag[w_lkp_idx] == w_lkp_tag);
  assign w_lkp_taken = w_lkp_hit && r_ctr[w_lkp_idx][CTR_W-1];

  assign pred_hit_o    = w_lkp_hit;
  assign pred_taken_o  = w_lkp_taken;
  assign pred_target_o = w_lkp_taken ? r_tgt[w_lkp_idx] : (lkp_pc_i + ADDR_W'(4));
  assign mispred_cnt_o = r_mispred_cnt;

  assign w_upd_idx = upd_pc_i[IDX_W+1:2];
  assign w_upd_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Saturating step of the indexed counter in the direction of the outcome.
  always_comb begin
    w_ctr_cur = r_ctr[w_upd_idx];
    w_ctr_nxt = w_ctr_cur;
    if (upd_taken_i) begin
      if (w_ctr_cur != CTR_MAX) w_ctr_nxt = w_ctr_cur + CTR_W'(1);
    end else begin
      if (w_ctr_cur != '0) w_ctr_nxt = w_ctr_cur - CTR_W'(1);
    end
  end

  // Entry state. Flush outranks a concurrent update, which is dropped.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i] <= '0;
        r_tgt[i] <= '0;
        r_ctr[i] <= CTR_WNT;
      end
    end else if (flush_i) begin
      r_valid <= '0;
    end else if (upd_valid_i) begin
      if (w_upd_hit) begin
        r_ctr[w_upd_idx] <= w_ctr_nxt;
        if (upd_taken_i) r_tgt[w_upd_idx] <= upd_target_i;
      end else if (upd_taken_i) begin
        // Miss on a taken branch replaces whatever alias occupies the slot.
        r_valid[w_upd_idx] <= 1'b1;
        r_tag[w_upd_idx]   <= w_upd_tag;
        r_tgt[w_upd_idx]   <= upd_target_i;
        r_ctr[w_upd_idx]   <= CTR_WT;
      end
    end
  end

  // Mispredict counter keeps counting through a flush; clear beats increment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mispred_cnt <= '0;
    end else if (perf_clr_i) begin
      r_mispred_cnt <= '0;
    end else if (upd_valid_i && upd_mispred_i && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
      r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (ADDR_W=32, ENTRIES=16, CTR_W=2).
// Directed scenarios plus randomized traffic compared against a table-level model.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] lkp_pc_i;
  logic        pred_hit_o;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_mispred_i;
  logic        flush_i;
  logic        perf_clr_i;
  logic [31:0] mispred_cnt_o;

  int errors = 0;
  int checks = 0;

  branch_predictor dut (
    .clk_i(clk_i), .rst_i(rst_i), .lkp_pc_i(lkp_pc_i),
    .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .upd_target_i(upd_target_i), .upd_mispred_i(upd_mispred_i),
    .flush_i(flush_i), .perf_clr_i(perf_clr_i), .mispred_cnt_o(mispred_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: table of entries kept as plain integers.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  longint      m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_cnt = 0;
  endtask

  // Apply the rules for the inputs currently driven, as of the coming edge.
  task automatic model_edge();
    int idx;
    logic [25:0] tag;
    if (perf_clr_i) m_cnt = 0;
    else if (upd_valid_i && upd_mispred_i && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (flush_i) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
    end else if (upd_valid_i) begin
      idx = int'((upd_pc_i / 4) % 16);
      tag = 26'(upd_pc_i / 64);
      if (m_valid[idx] && m_tag[idx] == tag) begin
        if (upd_taken_i) begin
          m_ctr[idx] = (m_ctr[idx] + 1 > 3) ? 3 : m_ctr[idx] + 1;
          m_tgt[idx] = upd_target_i;
        end else begin
          m_ctr[idx] = (m_ctr[idx] - 1 < 0) ? 0 : m_ctr[idx] - 1;
        end
      end else if (upd_taken_i) begin
        m_valid[idx] = 1; m_tag[idx] = tag; m_tgt[idx] = upd_target_i; m_ctr[idx] = 2;
      end
    end
  endtask

  task automatic model_lookup(input logic [31:0] pc, output logic h, output logic t,
                              output logic [31:0] tg);
    int idx;
    idx = int'((pc / 4) % 16);
    h  = m_valid[idx] && (m_tag[idx] == 26'(pc / 64));
    t  = h && (m_ctr[idx] >= 2);
    tg = t ? m_tgt[idx] : pc + 32'd4;
  endtask

  task automatic idle();
    upd_valid_i = 0; upd_pc_i = '0; upd_taken_i = 0; upd_target_i = '0;
    upd_mispred_i = 0; flush_i = 0; perf_clr_i = 0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                           input logic mp);
    upd_valid_i = 1; upd_pc_i = pc; upd_taken_i = tk; upd_target_i = tg; upd_mispred_i = mp;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_i = 0; lkp_pc_i = 32'h44; idle();
    #12;
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b0, 1'b0, 32'h48}) begin
      errors++; $display("FAIL reset_lookup got %b/%b/%h want 0/0/00000048",
                         pred_hit_o, pred_taken_o, pred_target_o);
    end
    checks++;
    if (mispred_cnt_o !== 32'd0) begin
      errors++; $display("FAIL reset_cnt got %0d want 0", mispred_cnt_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1;
    model_reset();
    tick();
    lkp_pc_i = 32'hFFFF_FFFF; #1;
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b0, 1'b0, 32'h3}) begin
      errors++; $display("FAIL wrap_target got %b/%b/%h want 0/0/00000003",
                         pred_hit_o, pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_alloc();
    do_update(32'h44, 1, 32'h100, 0);
    lkp_pc_i = 32'h44; #1;
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b1, 1'b1, 32'h100}) begin
      errors++; $display("FAIL alloc got %b/%b/%h want 1/1/00000100",
                         pred_hit_o, pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_counter_sat();
    // ctr 2 -> 1 -> 0
    do_update(32'h44, 0, 32'h0, 0);
    do_update(32'h44, 0, 32'h0, 0);
    lkp_pc_i = 32'h44; #1;
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b1, 1'b0, 32'h48}) begin
      errors++; $display("FAIL ctr_zero got %b/%b/%h want 1/0/00000048",
                         pred_hit_o, pred_taken_o, pred_target_o);
    end
    // stays 0, then one taken gives 1 (still not-taken) if there was no wrap
    do_update(32'h44, 0, 32'h0, 0);
    do_update(32'h44, 1, 32'h100, 0);
    #1;
    checks++;
    if (pred_taken_o !== 1'b0) begin
      errors++; $display("FAIL ctr_low_sat got taken=%b want 0", pred_taken_o);
    end
    // 1 -> 2 -> 3 -> 3, then one not-taken leaves 2 (still taken)
    do_update(32'h44, 1, 32'h100, 0);
    do_update(32'h44, 1, 32'h100, 0);
    #1;
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b1, 1'b1, 32'h100}) begin
      errors++; $display("FAIL ctr_three got %b/%b/%h want 1/1/00000100",
                         pred_hit_o, pred_taken_o, pred_target_o);
    end
    do_update(32'h44, 1, 32'h100, 0);
    do_update(32'h44, 0, 32'h0, 0);
    #1;
    checks++;
    if (pred_taken_o !== 1'b1) begin
      errors++; $display("FAIL ctr_high_sat got taken=%b want 1", pred_taken_o);
    end
  endtask

  task automatic test_alias();
    do_update(32'h84, 1, 32'h200, 0);
    lkp_pc_i = 32'h44; #1;
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b0, 1'b0, 32'h48}) begin
      errors++; $display("FAIL alias_old got %b/%b/%h want 0/0/00000048",
                         pred_hit_o, pred_taken_o, pred_target_o);
    end
    lkp_pc_i = 32'h84; #1;
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b1, 1'b1, 32'h200}) begin
      errors++; $display("FAIL alias_new got %b/%b/%h want 1/1/00000200",
                         pred_hit_o, pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_same_cycle();
    upd_valid_i = 1; upd_pc_i = 32'h44; upd_taken_i = 1; upd_target_i = 32'h100;
    lkp_pc_i = 32'h44; #1;
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b0, 1'b0, 32'h48}) begin
      errors++; $display("FAIL same_cycle_old got %b/%b/%h want 0/0/00000048",
                         pred_hit_o, pred_taken_o, pred_target_o);
    end
    tick();
    idle(); #1;
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b1, 1'b1, 32'h100}) begin
      errors++; $display("FAIL same_cycle_next got %b/%b/%h want 1/1/00000100",
                         pred_hit_o, pred_taken_o, pred_target_o);
    end
  endtask

  task automatic test_flush();
    flush_i = 1;
    do_update(32'h84, 1, 32'h300, 1);
    lkp_pc_i = 32'h44; #1;
    checks++;
    if (pred_hit_o !== 1'b0) begin
      errors++; $display("FAIL flush_hit_44 got %b want 0", pred_hit_o);
    end
    lkp_pc_i = 32'h84; #1;
    checks++;
    if ({pred_hit_o, pred_target_o} !== {1'b0, 32'h88}) begin
      errors++; $display("FAIL flush_hit_84 got %b/%h want 0/00000088", pred_hit_o, pred_target_o);
    end
    checks++;
    if (mispred_cnt_o !== 32'd1) begin
      errors++; $display("FAIL flush_cnt got %0d want 1", mispred_cnt_o);
    end
  endtask

  task automatic test_perf_clr();
    do_update(32'h10, 0, 32'h0, 1);
    checks++;
    if (mispred_cnt_o !== 32'd2) begin
      errors++; $display("FAIL cnt_inc got %0d want 2", mispred_cnt_o);
    end
    perf_clr_i = 1;
    do_update(32'h10, 0, 32'h0, 1);
    checks++;
    if (mispred_cnt_o !== 32'd0) begin
      errors++; $display("FAIL perf_clr got %0d want 0", mispred_cnt_o);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = $urandom;
    pc[31:6] = 26'($urandom_range(0, 3));
    return pc;
  endfunction

  task automatic test_random();
    logic eh, et;
    logic [31:0] eg;
    for (int n = 0; n < 600; n++) begin
      upd_valid_i   = ($urandom_range(0, 2) != 0);
      upd_pc_i      = rand_pc();
      upd_taken_i   = 1'($urandom_range(0, 1));
      upd_target_i  = $urandom;
      upd_mispred_i = 1'($urandom_range(0, 1));
      flush_i       = ($urandom_range(0, 31) == 0);
      perf_clr_i    = ($urandom_range(0, 23) == 0);
      lkp_pc_i      = (n % 3 == 0) ? upd_pc_i : rand_pc();
      #1;
      model_lookup(lkp_pc_i, eh, et, eg);
      checks++;
      if ({pred_hit_o, pred_taken_o, pred_target_o} !== {eh, et, eg}) begin
        errors++; $display("FAIL rand_lookup[%0d] pc=%h got %b/%b/%h want %b/%b/%h", n, lkp_pc_i,
                           pred_hit_o, pred_taken_o, pred_target_o, eh, et, eg);
      end
      checks++;
      if (mispred_cnt_o !== 32'(m_cnt)) begin
        errors++; $display("FAIL rand_cnt[%0d] got %0d want %0d", n, mispred_cnt_o, m_cnt);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    do_update(32'h48, 1, 32'h400, 1);
    lkp_pc_i = 32'h48;
    // Mid-cycle: assert reset with an update pending.
    #2;
    upd_valid_i = 1; upd_pc_i = 32'h48; upd_taken_i = 1; upd_target_i = 32'h500;
    upd_mispred_i = 1;
    rst_i = 0;
    #1;
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b0, 1'b0, 32'h4C}) begin
      errors++; $display("FAIL async_rst_lookup got %b/%b/%h want 0/0/0000004c",
                         pred_hit_o, pred_taken_o, pred_target_o);
    end
    checks++;
    if (mispred_cnt_o !== 32'd0) begin
      errors++; $display("FAIL async_rst_cnt got %0d want 0", mispred_cnt_o);
    end
    @(posedge clk_i); #1;
    idle();
    rst_i = 1;
    model_reset();
    #1;
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_target_o, mispred_cnt_o} !== {1'b0, 1'b0, 32'h4C, 32'd0}) begin
      errors++; $display("FAIL post_rst got %b/%b/%h cnt=%0d want 0/0/0000004c cnt=0",
                         pred_hit_o, pred_taken_o, pred_target_o, mispred_cnt_o);
    end
    // A hit on a fresh allocation after reset starts weakly taken.
    do_update(32'h48, 1, 32'h600, 0);
    #1;
    checks++;
    if ({pred_hit_o, pred_taken_o, pred_target_o} !== {1'b1, 1'b1, 32'h600}) begin
      errors++; $display("FAIL post_rst_alloc got %b/%b/%h want 1/1/00000600",
                         pred_hit_o, pred_taken_o, pred_target_o);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alloc();
    test_counter_sat();
    test_alias();
    test_same_cycle();
    test_flush();
    test_perf_clr();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
